// File: rtl/dcache_nway_if.sv
// rtl/dcache_nway_if.sv - datapath and memory-arbiter signal bundle for dcache_nway
interface dcache_nway_if;
  logic        dREN;
  logic        dWEN;
  logic        halt;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        mREN;
  logic        mWEN;
  logic [31:0] maddr;
  logic [31:0] mstore;
  logic [31:0] mload;
  logic        mwait;

  modport slave (
    input  dREN, dWEN, halt, daddr, dstore, mload, mwait,
    output dhit, dmemload, flushed, hit_count, miss_count, mREN, mWEN, maddr, mstore
  );

  modport master (
    output dREN, dWEN, halt, daddr, dstore, mload, mwait,
    input  dhit, dmemload, flushed, hit_count, miss_count, mREN, mWEN, maddr, mstore
  );
endinterface

// File: rtl/dcache_nway.sv
// rtl/dcache_nway.sv - N-way set-associative write-back data cache with LRU and flush engine
module dcache_nway #(
  parameter int NSETS    = 8,
  parameter int NWAYS    = 2,
  parameter int BLKWORDS = 2
) (
  input logic          CLK,
  input logic          nRST,
  dcache_nway_if.slave bus
);
  localparam int OFFB = $clog2(BLKWORDS);
  localparam int IDXB = $clog2(NSETS);
  localparam int WAYB = $clog2(NWAYS);
  localparam int TAGB = 30 - OFFB - IDXB;
  localparam int NL   = NSETS * NWAYS;
  localparam int LB   = IDXB + WAYB + 1;

  typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH_SCAN, FLUSH_WB, FLUSHED} state_t;

  state_t state, next;

  logic            valid [NSETS][NWAYS];
  logic            dirty [NSETS][NWAYS];
  logic [TAGB-1:0] tags  [NSETS][NWAYS];
  logic [31:0]     data  [NSETS][NWAYS][BLKWORDS];
  logic [WAYB-1:0] age   [NSETS][NWAYS];

  logic [WAYB-1:0] vic, vic_sel, hit_way;
  logic [OFFB-1:0] wcnt;
  logic [LB-1:0]   lcnt;
  logic [31:0]     hit_cnt, miss_cnt;
  logic            hit, req, last;

  logic [OFFB-1:0] woff;
  logic [IDXB-1:0] idx, fset, wset;
  logic [TAGB-1:0] rtag;
  logic [WAYB-1:0] fway, wway;

  assign woff = bus.daddr[2 +: OFFB];
  assign idx  = bus.daddr[2+OFFB +: IDXB];
  assign rtag = bus.daddr[31 -: TAGB];
  assign req  = bus.dREN | bus.dWEN;
  assign last = (wcnt == OFFB'(BLKWORDS-1));

  // Flush line counter walks set-major: L = set*NWAYS + way.
  assign fset = lcnt[WAYB +: IDXB];
  assign fway = lcnt[WAYB-1:0];
  assign wset = (state == FLUSH_WB) ? fset : idx;
  assign wway = (state == FLUSH_WB) ? fway : vic;

  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (valid[idx][w] && tags[idx][w] == rtag) begin
        hit     = 1'b1;
        hit_way = WAYB'(w);
      end
    end
  end

  // Invalid ways take precedence over the LRU way; descending loops let the lowest index win.
  always_comb begin
    vic_sel = '0;
    for (int w = NWAYS-1; w >= 0; w--)
      if (age[idx][w] == WAYB'(NWAYS-1)) vic_sel = WAYB'(w);
    for (int w = NWAYS-1; w >= 0; w--)
      if (!valid[idx][w]) vic_sel = WAYB'(w);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next         = state;
    bus.dhit     = 1'b0;
    bus.dmemload = '0;
    bus.flushed  = 1'b0;
    bus.mREN     = 1'b0;
    bus.mWEN     = 1'b0;
    bus.maddr    = '0;
    bus.mstore   = '0;
    case (state)
      IDLE: begin
        if (bus.halt) begin
          next = FLUSH_SCAN;
        end else if (req) begin
          if (hit) begin
            bus.dhit     = 1'b1;
            bus.dmemload = data[idx][hit_way][woff];
          end else begin
            next = (valid[idx][vic_sel] && dirty[idx][vic_sel]) ? WB : FILL;
          end
        end
      end
      WB, FLUSH_WB: begin
        bus.mWEN   = 1'b1;
        bus.maddr  = {tags[wset][wway], wset, wcnt, 2'b00};
        bus.mstore = data[wset][wway][wcnt];
        if (!bus.mwait && last) next = (state == WB) ? FILL : FLUSH_SCAN;
      end
      FILL: begin
        bus.mREN  = 1'b1;
        bus.maddr = {rtag, idx, wcnt, 2'b00};
        if (!bus.mwait && last) next = IDLE;
      end
      FLUSH_SCAN: begin
        if (lcnt == LB'(NL))                           next = FLUSHED;
        else if (valid[fset][fway] && dirty[fset][fway]) next = FLUSH_WB;
      end
      FLUSHED: bus.flushed = 1'b1;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < NSETS; s++) begin
        for (int w = 0; w < NWAYS; w++) begin
          valid[s][w] <= 1'b0;
          dirty[s][w] <= 1'b0;
          tags[s][w]  <= '0;
          age[s][w]   <= WAYB'(w);
          for (int b = 0; b < BLKWORDS; b++) data[s][w][b] <= '0;
        end
      end
      vic      <= '0;
      wcnt     <= '0;
      lcnt     <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.halt) begin
            lcnt <= '0;
          end else if (req) begin
            if (hit) begin
              if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
              for (int w = 0; w < NWAYS; w++)
                if (age[idx][w] < age[idx][hit_way]) age[idx][w] <= age[idx][w] + 1'b1;
              age[idx][hit_way] <= '0;
              if (bus.dWEN) begin
                data[idx][hit_way][woff] <= bus.dstore;
                dirty[idx][hit_way]      <= 1'b1;
              end
            end else begin
              if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
              vic  <= vic_sel;
              wcnt <= '0;
            end
          end
        end
        // wcnt wraps to zero after the last word, ready for the next burst.
        WB, FLUSH_WB: begin
          if (!bus.mwait) begin
            wcnt <= wcnt + 1'b1;
            if (last) begin
              dirty[wset][wway] <= 1'b0;
              if (state == FLUSH_WB) lcnt <= lcnt + 1'b1;
            end
          end
        end
        FILL: begin
          if (!bus.mwait) begin
            data[idx][vic][wcnt] <= bus.mload;
            wcnt <= wcnt + 1'b1;
            if (last) begin
              valid[idx][vic] <= 1'b1;
              dirty[idx][vic] <= 1'b0;
              tags[idx][vic]  <= rtag;
            end
          end
        end
        FLUSH_SCAN: begin
          if (lcnt != LB'(NL) && !(valid[fset][fway] && dirty[fset][fway]))
            lcnt <= lcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_nway.sv
// tb/tb_dcache_nway.sv - table-driven and randomized checks of dcache_nway against memory/LRU models
module tb_dcache_nway;
  localparam int NSETS    = 8;
  localparam int NWAYS    = 2;
  localparam int BLKWORDS = 2;
  localparam int OFFB     = $clog2(BLKWORDS);
  localparam int IDXB     = $clog2(NSETS);

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  dcache_nway_if bus();

  dcache_nway #(.NSETS(NSETS), .NWAYS(NWAYS), .BLKWORDS(BLKWORDS)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int nvec  = 0;
  int nfail = 0;
  logic [31:0] mem  [logic [31:0]];
  logic [31:0] gold [logic [31:0]];
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_d[$];
  int stall_mode = 0;
  int stall_left = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    nvec++;
    nfail++;
    $display("FAIL %s: wait bound expired before the expected event", name);
  endtask

  function automatic logic [31:0] defval(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rdmem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : defval(a);
  endfunction

  function automatic int pick_stall();
    return (stall_mode < 0) ? int'($urandom_range(2, 0)) : stall_mode;
  endfunction

  // Memory arbiter model: decides mwait at the falling edge, so a transfer seen here completes at the next rise.
  initial begin
    logic        prev_wait;
    logic [31:0] prev_addr, prev_store;
    prev_wait  = 1'b0;
    prev_addr  = '0;
    prev_store = '0;
    bus.mwait  = 1'b0;
    bus.mload  = '0;
    forever begin
      @(negedge CLK);
      if (bus.mREN && bus.mWEN) chk("mren_mwen_exclusive", 32'(bus.mREN & bus.mWEN), 32'd0);
      if (prev_wait && (bus.mREN || bus.mWEN)) begin
        chk("maddr_stable", bus.maddr, prev_addr);
        if (bus.mWEN) chk("mstore_stable", bus.mstore, prev_store);
      end
      if (bus.mREN || bus.mWEN) begin
        bus.mload = rdmem(bus.maddr);
        if (stall_left > 0) begin
          bus.mwait = 1'b1;
          stall_left--;
        end else begin
          bus.mwait = 1'b0;
          if (bus.mWEN) begin
            mem[bus.maddr] = bus.mstore;
            wlog_a.push_back(bus.maddr);
            wlog_d.push_back(bus.mstore);
          end
          stall_left = pick_stall();
        end
      end else begin
        bus.mwait  = 1'b0;
        stall_left = pick_stall();
      end
      prev_wait  = (bus.mREN || bus.mWEN) && bus.mwait;
      prev_addr  = bus.maddr;
      prev_store = bus.mstore;
    end
  end

  task automatic do_reset(input bit check);
    @(negedge CLK);
    nRST       = 1'b0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    bus.halt   = 1'b0;
    bus.daddr  = '0;
    bus.dstore = '0;
    @(negedge CLK);
    if (check) begin
      chk("rst_dhit", 32'(bus.dhit), 32'd0);
      chk("rst_flushed", 32'(bus.flushed), 32'd0);
      chk("rst_mREN", 32'(bus.mREN), 32'd0);
      chk("rst_mWEN", 32'(bus.mWEN), 32'd0);
      chk("rst_maddr", bus.maddr, 32'd0);
      chk("rst_mstore", bus.mstore, 32'd0);
      chk("rst_dmemload", bus.dmemload, 32'd0);
      chk("rst_hit_count", bus.hit_count, 32'd0);
      chk("rst_miss_count", bus.miss_count, 32'd0);
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Called just after a rising edge; returns after the hitting edge with the request dropped.
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic first_hit, output logic [31:0] rdata, output int lat);
    bus.dWEN   = wr;
    bus.dREN   = !wr || ($urandom_range(1, 0) == 1);
    bus.daddr  = a;
    bus.dstore = d;
    lat   = 0;
    rdata = '0;
    forever begin
      @(negedge CLK);
      if (bus.dhit) begin
        rdata = bus.dmemload;
        break;
      end
      lat++;
      if (lat > 200) begin
        bound_fail("access_timeout");
        break;
      end
    end
    first_hit = (lat == 0);
    @(posedge CLK);
    #1;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
  endtask

  task automatic wait_flushed(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.flushed && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.flushed) bound_fail(name);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[7];
    logic [31:0] exp_wa[4];
    logic [31:0] exp_wd[4];
    logic        fh;
    logic [31:0] rd;
    int          lat;
    int          misses;
    int unsigned lru[NSETS][$];

    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.halt = 1'b0; bus.daddr = '0; bus.dstore = '0;
    mem[32'h40] = 32'hA0; mem[32'h44] = 32'hA1;
    mem[32'h80] = 32'hB0; mem[32'h84] = 32'h0;
    mem[32'hC0] = 32'hC0; mem[32'hC4] = 32'hC1;

    tbl[0] = '{1'b0, 32'h40, 32'h0,  32'hA0, 3};
    tbl[1] = '{1'b0, 32'h44, 32'h0,  32'hA1, 0};
    tbl[2] = '{1'b0, 32'h80, 32'h0,  32'hB0, 3};
    tbl[3] = '{1'b1, 32'h80, 32'h55, 32'h0,  3'd0};
    tbl[4] = '{1'b0, 32'h40, 32'h0,  32'hA0, 0};
    tbl[5] = '{1'b0, 32'hC0, 32'h0,  32'hC0, 5};
    tbl[6] = '{1'b0, 32'h80, 32'h0,  32'h55, 3};

    do_reset(1'b1);
    stall_mode = 0;
    wlog_a.delete(); wlog_d.delete();
    for (int i = 0; i < 7; i++) begin
      access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, fh, rd, lat);
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      if (!tbl[i].wr) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
    end
    chk("conflict_wb_count", 32'(wlog_a.size()), 32'd2);
    exp_wa[0] = 32'h80; exp_wd[0] = 32'h55;
    exp_wa[1] = 32'h84; exp_wd[1] = 32'h0;
    for (int k = 0; k < 2; k++) begin
      if (k < wlog_a.size()) begin
        chk($sformatf("conflict_wb%0d_addr", k), wlog_a[k], exp_wa[k]);
        chk($sformatf("conflict_wb%0d_data", k), wlog_d[k], exp_wd[k]);
      end
    end
    chk("tbl_hit_count", bus.hit_count, 32'd7);
    chk("tbl_miss_count", bus.miss_count, 32'd4);

    // Slow memory: three wait cycles before each word of the fill.
    stall_mode = 3;
    access(1'b0, 32'h100, 32'h0, fh, rd, lat);
    chk("stall_fill_latency", 32'(lat), 32'd9);
    chk("stall_fill_rdata", rd, 32'h5A5A_0100);
    stall_mode = 0;

    // Flush of two dirty lines in sets 0 and 5.
    do_reset(1'b0);
    access(1'b1, 32'h40, 32'h11, fh, rd, lat);
    chk("flush_prep0_latency", 32'(lat), 32'd3);
    access(1'b1, 32'h68, 32'h22, fh, rd, lat);
    chk("flush_prep1_latency", 32'(lat), 32'd3);
    wlog_a.delete(); wlog_d.delete();
    bus.halt = 1'b1;
    wait_flushed("flush_done", 100);
    chk("flushed_flag", 32'(bus.flushed), 32'd1);
    chk("flush_wb_count", 32'(wlog_a.size()), 32'(2 * BLKWORDS));
    exp_wa[0] = 32'h40; exp_wd[0] = 32'h11;
    exp_wa[1] = 32'h44; exp_wd[1] = 32'hA1;
    exp_wa[2] = 32'h68; exp_wd[2] = 32'h22;
    exp_wa[3] = 32'h6C; exp_wd[3] = 32'h5A5A_006C;
    for (int k = 0; k < 4; k++) begin
      if (k < wlog_a.size()) begin
        chk($sformatf("flush_wb%0d_addr", k), wlog_a[k], exp_wa[k]);
        chk($sformatf("flush_wb%0d_data", k), wlog_d[k], exp_wd[k]);
      end
    end
    bus.dREN  = 1'b1;
    bus.daddr = 32'h40;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk("flushed_no_dhit", 32'(bus.dhit), 32'd0);
      chk("flushed_no_mREN", 32'(bus.mREN), 32'd0);
      chk("flushed_sticky", 32'(bus.flushed), 32'd1);
    end
    bus.dREN = 1'b0;
    bus.halt = 1'b0;

    // Reset asserted during the second fill word.
    do_reset(1'b0);
    bus.dREN  = 1'b1;
    bus.daddr = 32'h40;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chk("midfill_mREN_before", 32'(bus.mREN), 32'd1);
    chk("midfill_maddr", bus.maddr, 32'h44);
    #1 nRST = 1'b0;
    #1;
    chk("midfill_mREN_drop", 32'(bus.mREN), 32'd0);
    chk("midfill_miss_count_clr", bus.miss_count, 32'd0);
    bus.dREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    access(1'b0, 32'h40, 32'h0, fh, rd, lat);
    chk("after_rst_latency", 32'(lat), 32'd3);
    chk("after_rst_rdata", rd, 32'h11);

    // Randomized traffic against a recency-list cache model and a golden memory image.
    do_reset(1'b0);
    stall_mode = -1;
    gold.delete();
    foreach (mem[k]) gold[k] = mem[k];
    for (int s = 0; s < NSETS; s++) lru[s].delete();
    misses = 0;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] tg, ix, wo, a, d;
      bit          wr, exp_hit;
      int          pos;
      tg = 32'($urandom_range(5, 0));
      ix = 32'($urandom_range(NSETS - 1, 0));
      wo = 32'($urandom_range(BLKWORDS - 1, 0));
      a  = (tg << (2 + OFFB + IDXB)) | (ix << (2 + OFFB)) | (wo << 2);
      d  = $urandom;
      wr = ($urandom_range(1, 0) == 1);
      exp_hit = 1'b0;
      pos = 0;
      for (int k = 0; k < lru[ix].size(); k++) begin
        if (lru[ix][k] == tg) begin
          exp_hit = 1'b1;
          pos = k;
        end
      end
      if (exp_hit) lru[ix].delete(pos);
      else begin
        misses++;
        if (lru[ix].size() == NWAYS) void'(lru[ix].pop_back());
      end
      lru[ix].push_front(tg);
      access(wr, a, d, fh, rd, lat);
      chk($sformatf("rnd%0d_hit", i), 32'(fh), 32'(exp_hit));
      if (wr) gold[a] = d;
      else    chk($sformatf("rnd%0d_rdata", i), rd, gold.exists(a) ? gold[a] : defval(a));
    end
    chk("rnd_hit_count", bus.hit_count, 32'd300);
    chk("rnd_miss_count", bus.miss_count, 32'(misses));
    bus.halt = 1'b1;
    wait_flushed("rnd_flush_done", 2000);
    foreach (gold[k]) chk($sformatf("rnd_mem_%h", k), rdmem(k), gold[k]);
    bus.halt = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
